// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter placing NUM_CORES request channels in front of one
// single-port shared data memory. Adds atomic test-and-set, sticky halt
// tracking with all-halted detection, a saturating cycle counter and a
// watchdog timeout flag.
module shared_mem_arbiter #(
    parameter int unsigned NUM_CORES      = 2,
    parameter int unsigned W_DATA         = 32,
    parameter int unsigned W_ADDR         = 32,
    parameter int unsigned W_CNT          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 300
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [2*NUM_CORES-1:0]        core_cmd,
    input  logic [W_ADDR*NUM_CORES-1:0]   core_addr,
    input  logic [W_DATA*NUM_CORES-1:0]   core_wdata,
    output logic [NUM_CORES-1:0]          core_ack,
    output logic [W_DATA-1:0]             core_rdata,
    input  logic [NUM_CORES-1:0]          core_halt,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [W_ADDR-1:0]             mem_addr,
    output logic [W_DATA-1:0]             mem_wdata,
    input  logic [W_DATA-1:0]             mem_rdata,
    output logic                          all_halted,
    output logic [W_CNT-1:0]              cycle_count,
    output logic                          timeout
);

    localparam int unsigned W_IDX = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_READ  = 2'd1,
        CMD_WRITE = 2'd2,
        CMD_TAS   = 2'd3
    } cmd_t;

    state_t              state_q;
    logic [W_IDX-1:0]    rr_q;
    logic [W_IDX-1:0]    win_q;
    cmd_t                cmd_q;
    logic [W_ADDR-1:0]   addr_q;
    logic [W_DATA-1:0]   wdata_q;

    logic                mem_en_q;
    logic                mem_we_q;
    logic [W_ADDR-1:0]   mem_addr_q;
    logic [W_DATA-1:0]   mem_wdata_q;
    logic [NUM_CORES-1:0] ack_q;
    logic                rdata_sel_q;

    logic [NUM_CORES-1:0] req;
    logic                found;
    logic [W_IDX-1:0]    win_idx;
    int unsigned         srch;
    cmd_t                win_cmd;
    logic [W_ADDR-1:0]   win_addr;
    logic [W_DATA-1:0]   win_wdata;

    logic [NUM_CORES-1:0] halted_q;
    logic [NUM_CORES-1:0] halted_d;
    logic                all_halted_q;
    logic [W_CNT-1:0]    cnt_q;
    logic                timeout_q;
    logic                thresh_hit;

    // Per-core request flags: any command other than NONE is a request.
    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            req[i] = (core_cmd[2*i +: 2] != CMD_NONE);
        end
    end

    // First requesting core starting from the round-robin pointer.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        srch    = 0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            srch = (32'(rr_q) + k) % NUM_CORES;
            if (!found && req[srch]) begin
                found   = 1'b1;
                win_idx = W_IDX'(srch);
            end
        end
    end

    // Fields of the candidate winner, latched on the grant edge.
    always_comb begin
        win_cmd   = cmd_t'(core_cmd[2*win_idx +: 2]);
        win_addr  = core_addr[W_ADDR*win_idx +: W_ADDR];
        win_wdata = core_wdata[W_DATA*win_idx +: W_DATA];
    end

    // Arbitration FSM; memory/ack outputs are registered for the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            win_q       <= '0;
            cmd_q       <= CMD_NONE;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ack_q       <= '0;
            rdata_sel_q <= 1'b0;
        end else begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ack_q       <= '0;
            rdata_sel_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        win_q       <= win_idx;
                        cmd_q       <= win_cmd;
                        addr_q      <= win_addr;
                        wdata_q     <= win_wdata;
                        rr_q        <= W_IDX'((32'(win_idx) + 32'd1) % NUM_CORES);
                        state_q     <= ACCESS;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= (win_cmd == CMD_WRITE);
                        mem_addr_q  <= win_addr;
                        mem_wdata_q <= (win_cmd == CMD_WRITE) ? win_wdata : '0;
                    end
                end
                ACCESS: begin
                    state_q     <= RESP;
                    ack_q       <= NUM_CORES'(1) << win_q;
                    rdata_sel_q <= (cmd_q != CMD_WRITE);
                    if (cmd_q == CMD_TAS) begin
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= addr_q;
                        mem_wdata_q <= W_DATA'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign halted_d   = halted_q | core_halt;
    assign thresh_hit = (cnt_q == W_CNT'(TIMEOUT_CYCLES - 1));

    // Sticky halt mask, all-halted flag, saturating cycle counter and watchdog.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halted_q     <= '0;
            all_halted_q <= 1'b0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
        end else begin
            halted_q     <= halted_d;
            all_halted_q <= all_halted_q | (&halted_q);
            if (!all_halted_q && !timeout_q && (cnt_q != '1)) begin
                cnt_q <= cnt_q + W_CNT'(1);
            end
            // All-halted rising on this same edge takes precedence over the watchdog.
            if (!timeout_q && !all_halted_q && !(&halted_q) && thresh_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign core_ack    = ack_q;
    // Read data arrives from memory during RESP, so it is steered rather than registered.
    assign core_rdata  = rdata_sel_q ? mem_rdata : '0;
    assign all_halted  = all_halted_q;
    assign cycle_count = cnt_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Scoreboard bench for shared_mem_arbiter: per-core request drivers push
// expected transactions, a monitor pops them on each ack and checks grant
// order and return data against a transaction-level memory model.
module tb_shared_mem_arbiter;

    localparam int N  = 4;
    localparam int WD = 32;
    localparam int WA = 32;
    localparam int WC = 32;
    localparam int TO = 100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [2*N-1:0]    core_cmd;
    logic [WA*N-1:0]   core_addr;
    logic [WD*N-1:0]   core_wdata;
    logic [N-1:0]      core_ack;
    logic [WD-1:0]     core_rdata;
    logic [N-1:0]      core_halt;
    logic              mem_en;
    logic              mem_we;
    logic [WA-1:0]     mem_addr;
    logic [WD-1:0]     mem_wdata;
    logic [WD-1:0]     mem_rdata;
    logic              all_halted;
    logic [WC-1:0]     cycle_count;
    logic              timeout;

    shared_mem_arbiter #(
        .NUM_CORES(N), .W_DATA(WD), .W_ADDR(WA), .W_CNT(WC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(rst_n),
        .core_cmd(core_cmd), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_ack(core_ack), .core_rdata(core_rdata), .core_halt(core_halt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .all_halted(all_halted), .cycle_count(cycle_count), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    typedef enum int { M_OFF, M_SINGLE, M_CONT, M_TAS, M_RAND, M_SOLO } mode_t;

    int          compared = 0;
    int          mismatched = 0;
    mode_t       mode = M_OFF;
    int          rem [N];
    txn_t        pend [N][$];
    int          run = 0;
    int          n_edge;
    int          tas_zero = 0;
    int          first_ack = -1;
    logic [31:0] ram [0:4095];
    logic [31:0] ram_rdata;
    logic [31:0] mem_m [0:4095];
    logic [N-1:0] req_now, req_h1, req_h2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic txn_t gen(input int i);
        txn_t t;
        t.cmd = 2'd0; t.addr = '0; t.data = '0;
        case (mode)
            M_SINGLE: begin t.cmd = 2'd1; t.addr = 32'h800; end
            M_CONT:   begin t.cmd = 2'd2; t.addr = 32'h800 + i; t.data = i + 1; end
            M_TAS:    begin t.cmd = 2'd3; t.addr = 32'h900; end
            M_SOLO:   begin t.cmd = 2'd2; t.addr = 32'h805; t.data = 32'hABCD; end
            M_RAND:   begin
                t.cmd  = 2'($urandom_range(3, 1));
                t.addr = 32'h900 + $urandom_range(7);
                t.data = $urandom;
            end
            default: ;
        endcase
        return t;
    endfunction

    // Behavioural synchronous RAM: read data one cycle after an enabled read.
    initial begin
        for (int k = 0; k < 4096; k++) ram[k] = '0;
        ram[12'h800] = 32'hDEADBEEF;
        ram_rdata = '0;
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) ram[mem_addr[11:0]] <= mem_wdata;
                else        ram_rdata <= ram[mem_addr[11:0]];
            end
        end
    end
    assign mem_rdata = ram_rdata;

    always_comb begin
        for (int i = 0; i < N; i++) req_now[i] = (core_cmd[2*i +: 2] != 2'd0);
    end

    always @(posedge clk) begin
        req_h1 <= req_now;
        req_h2 <= req_h1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n_edge <= 0;
        else        n_edge <= n_edge + 1;
    end

    // Request drivers: a core issues a new request when idle or just acked.
    initial begin
        txn_t t;
        core_cmd = '0; core_addr = '0; core_wdata = '0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                core_cmd = '0;
                for (int i = 0; i < N; i++) pend[i].delete();
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (core_ack[i] || core_cmd[2*i +: 2] == 2'd0) begin
                        if (rem[i] > 0 && !(mode == M_RAND && $urandom_range(3) == 0)) begin
                            t = gen(i);
                            core_cmd[2*i +: 2]    = t.cmd;
                            core_addr[32*i +: 32] = t.addr;
                            core_wdata[32*i +: 32] = t.data;
                            pend[i].push_back(t);
                            rem[i]--;
                        end else begin
                            core_cmd[2*i +: 2] = 2'd0;
                        end
                    end
                end
            end
        end
    end

    // Monitor: on every ack, check the round-robin winner and the returned data.
    initial begin
        int   ptr_m;
        int   tick;
        int   last_ack;
        int   w;
        int   ew;
        int   idx;
        txn_t t;
        logic [31:0] exp_d;
        for (int k = 0; k < 4096; k++) mem_m[k] = '0;
        mem_m[12'h800] = 32'hDEADBEEF;
        ptr_m = 0; tick = 0; last_ack = -100;
        forever begin
            @(negedge clk);
            tick++;
            if (!rst_n) begin
                ptr_m = 0;
                last_ack = -100;
                continue;
            end
            if (core_ack != '0) begin
                check("ack_onehot", 64'($countones(core_ack)), 64'd1);
                w = -1;
                for (int k = 0; k < N; k++) if (core_ack[k] && w < 0) w = k;
                ew = -1;
                for (int k = 0; k < N; k++) begin
                    idx = (ptr_m + k) % N;
                    if (ew < 0 && req_h2[idx]) ew = idx;
                end
                check("rr_winner", 64'(w), 64'(ew));
                ptr_m = (w + 1) % N;
                if (first_ack < 0) first_ack = w;
                check("ack_gap_ge3", 64'(tick - last_ack >= 3), 64'd1);
                last_ack = tick;
                if (pend[w].size() == 0) begin
                    check("ack_without_request", 64'(w), 64'hFFFF);
                end else begin
                    t = pend[w].pop_front();
                    idx = int'(t.addr[11:0]);
                    exp_d = '0;
                    case (t.cmd)
                        2'd1: exp_d = mem_m[idx];
                        2'd2: mem_m[idx] = t.data;
                        2'd3: begin exp_d = mem_m[idx]; mem_m[idx] = 32'd1; end
                        default: ;
                    endcase
                    check("core_rdata", 64'(core_rdata), 64'(exp_d));
                    if (mode == M_TAS && core_rdata == 32'd0) tas_zero++;
                end
            end
        end
    end

    // Halt stimulus and counter/flag checks at chosen cycles after reset release.
    initial begin
        int ec;
        core_halt = '0;
        forever begin
            @(negedge clk);
            if (rst_n && run == 1 && (n_edge == 50 || n_edge == 51 || n_edge == 60)) begin
                ec = (n_edge >= 51) ? 51 : n_edge;
                check($sformatf("halt_count@%0d", n_edge), 64'(cycle_count), 64'(ec));
                check($sformatf("all_halted@%0d", n_edge), 64'(all_halted), 64'(n_edge >= 51));
                check($sformatf("no_timeout@%0d", n_edge), 64'(timeout), 64'd0);
            end
            if (rst_n && run == 2 && (n_edge == 99 || n_edge == 100 || n_edge == 150)) begin
                ec = (n_edge >= TO) ? TO : n_edge;
                check($sformatf("wd_count@%0d", n_edge), 64'(cycle_count), 64'(ec));
                check($sformatf("timeout@%0d", n_edge), 64'(timeout), 64'(n_edge >= TO));
                check($sformatf("wd_not_halted@%0d", n_edge), 64'(all_halted), 64'd0);
            end
            if (rst_n && run == 1 && n_edge == 19)      core_halt = 4'b1101;
            else if (rst_n && run == 1 && n_edge == 49) core_halt = 4'b0010;
            else                                        core_halt = '0;
        end
    end

    function automatic bit quiet();
        bit q = 1'b1;
        for (int i = 0; i < N; i++) if (rem[i] != 0 || pend[i].size() != 0) q = 1'b0;
        if (core_cmd != '0) q = 1'b0;
        return q;
    endfunction

    task automatic drain(input int budget, input string name);
        int c = 0;
        while (!quiet() && c < budget) begin
            @(posedge clk);
            c++;
        end
        check(name, 64'(c < budget), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic set_rem(input int v0, input int v1, input int v2, input int v3);
        rem[0] = v0; rem[1] = v1; rem[2] = v2; rem[3] = v3;
    endtask

    initial begin
        int c;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_flags", 64'({mem_en, mem_we, core_ack, all_halted, timeout}), 64'd0);
        check("reset_buses", 64'(mem_addr | mem_wdata | core_rdata | cycle_count), 64'd0);

        // Single read: grant on the first edge, ack on the second.
        mode = M_SINGLE; set_rem(1, 0, 0, 0); run = 1;
        @(posedge clk); #1 rst_n = 1'b1;
        c = 0;
        do begin @(negedge clk); c++; end while (!mem_en && c < 10);
        check("single_mem_en_cycle", 64'(n_edge), 64'd1);
        check("single_mem_addr_we", 64'({mem_we, mem_addr}), 64'h800);
        @(negedge clk);
        check("single_ack", 64'(core_ack), 64'b0001);
        check("single_rdata", 64'(core_rdata), 64'hDEADBEEF);
        drain(20, "single_drain");

        mode = M_CONT; set_rem(4, 4, 0, 0);
        drain(100, "cont_drain");
        check("cont_mem0", 64'(ram[12'h800]), 64'd1);
        check("cont_mem1", 64'(ram[12'h801]), 64'd2);

        mode = M_TAS; tas_zero = 0; set_rem(1, 1, 1, 1);
        drain(100, "tas_drain");
        check("tas_single_winner", 64'(tas_zero), 64'd1);
        check("tas_lock_mem", 64'(ram[12'h900]), 64'd1);

        mode = M_RAND; set_rem(40, 40, 40, 40);
        drain(3000, "rand1_drain");
        check("halt_freeze_end", 64'({timeout, cycle_count}), 64'd51);

        // Reset in the middle of a write access: transaction must vanish.
        run = 0;
        mode = M_SOLO; set_rem(0, 1, 0, 0);
        c = 0;
        do begin @(negedge clk); c++; end while (!(mem_en && mem_we) && c < 20);
        check("solo_reached_access", 64'(c < 20), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_flags", 64'({mem_en, mem_we, core_ack, all_halted}), 64'd0);
        check("async_reset_buses", 64'(mem_addr | mem_wdata | cycle_count), 64'd0);
        repeat (2) @(posedge clk);
        mode = M_CONT; set_rem(2, 2, 0, 0); first_ack = -1; run = 2;
        #1 rst_n = 1'b1;
        drain(100, "post_reset_drain");
        check("post_reset_first_winner", 64'(first_ack), 64'd0);
        check("dropped_write", 64'(ram[12'h805]), 64'd0);

        mode = M_RAND; set_rem(30, 30, 30, 30);
        drain(3000, "rand2_drain");
        for (int k = 0; k < 8; k++)
            check($sformatf("final_mem_%0h", 12'h900 + k), 64'(ram[12'h900 + k]), 64'(mem_m[12'h900 + k]));
        c = 0;
        while (n_edge < 155 && c < 500) begin @(posedge clk); c++; end
        check("wd_final", 64'({timeout, cycle_count}), {31'd0, 1'b1, 32'(TO)});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL sim_time_limit: simulation exceeded its time budget");
        $fatal(1, "time limit");
    end

endmodule
